// File: rtl/tb_dina_map_gen.sv
// Temp-buffer port A write-data mapper.
// Places L-lane CB read data into TB_dina (positive, reversed or new-landmark
// placement) and, on a single start pulse, plays out the 5-row motion-Jacobian
// pattern from Fxi_13/Fxi_23 captured at start.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | CB requests served; accepted nl_start latches Fxi and goes RUN
// RUN   | one Jacobian row per cycle (row index in cnt); CB requests dropped
module tb_dina_map_gen #(
    parameter int L              = 4,
    parameter int RSA_DW         = 32,
    parameter int NEW_W          = 2,
    parameter int OFS_DW         = 3,
    parameter int ONE            = 1,
    parameter int TB_DINA_SEL_DW = 3
) (
    input  logic                      clk,
    input  logic                      sys_rst,
    input  logic [TB_DINA_SEL_DW-1:0] TB_dina_sel,
    input  logic                      in_valid,
    input  logic [L*RSA_DW-1:0]       TB_dina_CB_douta,
    input  logic [OFS_DW-1:0]         new_ofs,
    input  logic                      nl_start,
    input  logic [RSA_DW-1:0]         Fxi_13,
    input  logic [RSA_DW-1:0]         Fxi_23,
    output logic [L*RSA_DW-1:0]       TB_dina,
    output logic [L-1:0]              TB_wea,
    output logic                      TB_dina_valid,
    output logic                      nl_busy,
    output logic                      nl_done,
    output logic                      drop_err
);

    localparam logic [RSA_DW-1:0] ONE_V = RSA_DW'(ONE);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [RSA_DW-1:0] f13_q;
    logic [RSA_DW-1:0] f23_q;

    logic              start_ok;
    logic              cb_ok;
    logic [L*RSA_DW-1:0] cb_dina;
    logic [L-1:0]        cb_wea;
    logic [L*RSA_DW-1:0] row_dina;
    logic [2:0]          row_idx;
    logic [RSA_DW-1:0]   row_f13;
    logic [RSA_DW-1:0]   row_f23;

    // A CB request that arrives together with an accepted nl_start carries
    // sel[2]=1 by necessity; it is still served (mode from sel[1:0]) and the
    // NL rows slip one cycle behind it.
    assign start_ok = (state == S_IDLE) && nl_start && TB_dina_sel[2];
    assign cb_ok    = (state == S_IDLE) && in_valid && (!TB_dina_sel[2] || start_ok);

    // CB lane placement for the selected mode.
    always_comb begin
        cb_dina = '0;
        cb_wea  = '0;
        case (TB_dina_sel[1:0])
            2'b01: begin
                cb_dina = TB_dina_CB_douta;
                cb_wea  = '1;
            end
            2'b10: begin
                for (int i = 0; i < L; i++)
                    cb_dina[i*RSA_DW +: RSA_DW] = TB_dina_CB_douta[(L-1-i)*RSA_DW +: RSA_DW];
                cb_wea = '1;
            end
            2'b11: begin
                // destinations past the last lane are simply never matched
                for (int k = 0; k < NEW_W; k++) begin
                    for (int i = 0; i < L; i++) begin
                        if (int'(new_ofs) + k == i) begin
                            cb_dina[i*RSA_DW +: RSA_DW] = TB_dina_CB_douta[k*RSA_DW +: RSA_DW];
                            cb_wea[i] = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Jacobian row contents; row 1 can be emitted straight from the inputs
    // on the start cycle, later rows use the latched terms.
    always_comb begin
        row_idx  = (state == S_IDLE) ? 3'd1 : cnt;
        row_f13  = (state == S_IDLE) ? Fxi_13 : f13_q;
        row_f23  = (state == S_IDLE) ? Fxi_23 : f23_q;
        row_dina = '0;
        case (row_idx)
            3'd1: row_dina[0*RSA_DW +: RSA_DW] = row_f13;
            3'd2: begin
                row_dina[0*RSA_DW +: RSA_DW] = ONE_V;
                row_dina[1*RSA_DW +: RSA_DW] = row_f23;
            end
            3'd3: row_dina[2*RSA_DW +: RSA_DW] = ONE_V;
            3'd4: begin
                row_dina[1*RSA_DW +: RSA_DW] = ONE_V;
                row_dina[2*RSA_DW +: RSA_DW] = row_f13;
            end
            3'd5: row_dina[2*RSA_DW +: RSA_DW] = row_f23;
            default: ;
        endcase
    end

    // Sequencer and registered outputs.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            f13_q         <= '0;
            f23_q         <= '0;
            TB_dina       <= '0;
            TB_wea        <= '0;
            TB_dina_valid <= 1'b0;
            nl_busy       <= 1'b0;
            nl_done       <= 1'b0;
            drop_err      <= 1'b0;
        end else begin
            TB_dina       <= '0;
            TB_wea        <= '0;
            TB_dina_valid <= 1'b0;
            nl_done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    nl_busy <= start_ok;
                    if (start_ok) begin
                        f13_q <= Fxi_13;
                        f23_q <= Fxi_23;
                        state <= S_RUN;
                    end
                    if (cb_ok) begin
                        TB_dina       <= cb_dina;
                        TB_wea        <= cb_wea;
                        TB_dina_valid <= 1'b1;
                        cnt           <= 3'd1;
                    end else if (start_ok) begin
                        TB_dina       <= row_dina;
                        TB_wea        <= '1;
                        TB_dina_valid <= 1'b1;
                        cnt           <= 3'd2;
                    end
                end
                S_RUN: begin
                    TB_dina       <= row_dina;
                    TB_wea        <= '1;
                    TB_dina_valid <= 1'b1;
                    nl_busy       <= 1'b1;
                    if (in_valid && !TB_dina_sel[2])
                        drop_err <= 1'b1;
                    if (cnt == 3'd5) begin
                        nl_done <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tb_dina_map_gen.sv
// Directed bench for the TB port A write-data mapper.
module tb_tb_dina_map_gen;

    localparam int L  = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic [2:0]        TB_dina_sel = '0;
    logic              in_valid = 1'b0;
    logic [L*DW-1:0]   TB_dina_CB_douta = '0;
    logic [2:0]        new_ofs = '0;
    logic              nl_start = 1'b0;
    logic [DW-1:0]     Fxi_13 = '0;
    logic [DW-1:0]     Fxi_23 = '0;
    logic [L*DW-1:0]   TB_dina;
    logic [L-1:0]      TB_wea;
    logic              TB_dina_valid;
    logic              nl_busy;
    logic              nl_done;
    logic              drop_err;

    int checks   = 0;
    int failures = 0;

    tb_dina_map_gen #(.L(L), .RSA_DW(DW), .NEW_W(2), .OFS_DW(3), .ONE(1), .TB_DINA_SEL_DW(3)) dut (
        .clk(clk), .sys_rst(sys_rst), .TB_dina_sel(TB_dina_sel), .in_valid(in_valid),
        .TB_dina_CB_douta(TB_dina_CB_douta), .new_ofs(new_ofs), .nl_start(nl_start),
        .Fxi_13(Fxi_13), .Fxi_23(Fxi_23), .TB_dina(TB_dina), .TB_wea(TB_wea),
        .TB_dina_valid(TB_dina_valid), .nl_busy(nl_busy), .nl_done(nl_done), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    function automatic logic [L*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
    endfunction

    // expected Jacobian row r (1..5)
    function automatic logic [L*DW-1:0] jrow(input int r, input int f13, input int f23);
        case (r)
            1: return pack4(f13, 0, 0, 0);
            2: return pack4(1, f23, 0, 0);
            3: return pack4(0, 0, 1, 0);
            4: return pack4(0, 1, f13, 0);
            default: return pack4(0, 0, f23, 0);
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        step(); step();
        checks++; if (TB_dina !== '0) begin failures++; $display("FAIL reset_dina got=%h exp=0", TB_dina); end
        checks++; if (TB_wea !== '0) begin failures++; $display("FAIL reset_wea got=%b exp=0000", TB_wea); end
        checks++; if ({TB_dina_valid, nl_busy, nl_done, drop_err} !== 4'b0000)
            begin failures++; $display("FAIL reset_flags got=%b exp=0000", {TB_dina_valid, nl_busy, nl_done, drop_err}); end
        sys_rst = 1'b0;
        step();
    endtask

    task automatic test_pos();
        TB_dina_sel = 3'b001; in_valid = 1'b1; TB_dina_CB_douta = pack4(10, 20, 30, 40);
        step();
        checks++; if (TB_dina !== pack4(10, 20, 30, 40)) begin failures++; $display("FAIL pos_dina got=%h exp=%h", TB_dina, pack4(10, 20, 30, 40)); end
        checks++; if (TB_wea !== 4'b1111) begin failures++; $display("FAIL pos_wea got=%b exp=1111", TB_wea); end
        checks++; if (TB_dina_valid !== 1'b1) begin failures++; $display("FAIL pos_valid got=%b exp=1", TB_dina_valid); end
        in_valid = 1'b0;
        step();
        checks++; if (TB_dina_valid !== 1'b0) begin failures++; $display("FAIL pos_after_valid got=%b exp=0", TB_dina_valid); end
        checks++; if (TB_dina !== '0) begin failures++; $display("FAIL pos_after_dina got=%h exp=0", TB_dina); end
    endtask

    task automatic test_neg();
        TB_dina_sel = 3'b010; in_valid = 1'b1; TB_dina_CB_douta = pack4(1, 2, 3, 4);
        step();
        checks++; if (TB_dina !== pack4(4, 3, 2, 1)) begin failures++; $display("FAIL neg_dina got=%h exp=%h", TB_dina, pack4(4, 3, 2, 1)); end
        checks++; if (TB_wea !== 4'b1111) begin failures++; $display("FAIL neg_wea got=%b exp=1111", TB_wea); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_new();
        TB_dina_sel = 3'b011; in_valid = 1'b1; TB_dina_CB_douta = pack4(7, 8, 55, 66); new_ofs = 3'd2;
        step();
        checks++; if (TB_dina !== pack4(0, 0, 7, 8)) begin failures++; $display("FAIL new2_dina got=%h exp=%h", TB_dina, pack4(0, 0, 7, 8)); end
        checks++; if (TB_wea !== 4'b1100) begin failures++; $display("FAIL new2_wea got=%b exp=1100", TB_wea); end
        new_ofs = 3'd3;
        step();
        checks++; if (TB_dina !== pack4(0, 0, 0, 7)) begin failures++; $display("FAIL new3_dina got=%h exp=%h", TB_dina, pack4(0, 0, 0, 7)); end
        checks++; if (TB_wea !== 4'b1000) begin failures++; $display("FAIL new3_wea got=%b exp=1000", TB_wea); end
        new_ofs = 3'd0;
        step();
        checks++; if (TB_dina !== pack4(7, 8, 0, 0) || TB_wea !== 4'b0011)
            begin failures++; $display("FAIL new0 got=%h/%b exp=%h/0011", TB_dina, TB_wea, pack4(7, 8, 0, 0)); end
        TB_dina_sel = 3'b000;
        step();
        checks++; if (TB_dina !== '0 || TB_wea !== 4'b0000 || TB_dina_valid !== 1'b1)
            begin failures++; $display("FAIL idle_mode got=%h/%b/%b exp=0/0000/1", TB_dina, TB_wea, TB_dina_valid); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_nl_sequence();
        int busy_cycles = 0;
        TB_dina_sel = 3'b100; nl_start = 1'b1; Fxi_13 = DW'(5); Fxi_23 = DW'(-3);
        for (int r = 1; r <= 5; r++) begin
            step();
            if (r == 1) begin nl_start = 1'b0; Fxi_13 = DW'(99); Fxi_23 = DW'(99); end
            if (nl_busy === 1'b1) busy_cycles++;
            checks++; if (TB_dina !== jrow(r, 5, -3) || TB_wea !== 4'b1111 || TB_dina_valid !== 1'b1)
                begin failures++; $display("FAIL nl_row%0d got=%h/%b/%b exp=%h/1111/1", r, TB_dina, TB_wea, TB_dina_valid, jrow(r, 5, -3)); end
            checks++; if (nl_done !== (r == 5)) begin failures++; $display("FAIL nl_done_row%0d got=%b exp=%b", r, nl_done, (r == 5)); end
        end
        step();
        checks++; if (busy_cycles != 5) begin failures++; $display("FAIL nl_busy_len got=%0d exp=5", busy_cycles); end
        checks++; if (TB_dina_valid !== 1'b0 || nl_busy !== 1'b0 || nl_done !== 1'b0)
            begin failures++; $display("FAIL nl_after got=%b%b%b exp=000", TB_dina_valid, nl_busy, nl_done); end
        checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL nl_no_drop got=%b exp=0", drop_err); end
    endtask

    task automatic test_drop_and_restart();
        TB_dina_sel = 3'b100; nl_start = 1'b1; Fxi_13 = DW'(2); Fxi_23 = DW'(4);
        for (int r = 1; r <= 5; r++) begin
            step();
            checks++; if (TB_dina !== jrow(r, 2, 4)) begin failures++; $display("FAIL drop_row%0d got=%h exp=%h", r, TB_dina, jrow(r, 2, 4)); end
            nl_start = 1'b0; in_valid = 1'b0; TB_dina_sel = 3'b100;
            if (r == 1) begin
                TB_dina_sel = 3'b001; in_valid = 1'b1; TB_dina_CB_douta = pack4(9, 9, 9, 9);
            end else if (r == 2) begin
                checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL drop_set got=%b exp=1", drop_err); end
                nl_start = 1'b1;
            end
        end
        step();
        checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL drop_sticky got=%b exp=1", drop_err); end
        checks++; if (TB_dina_valid !== 1'b0 || nl_busy !== 1'b0) begin failures++; $display("FAIL drop_after got=%b%b exp=00", TB_dina_valid, nl_busy); end
    endtask

    task automatic test_same_cycle();
        TB_dina_sel = 3'b101; in_valid = 1'b1; nl_start = 1'b1;
        TB_dina_CB_douta = pack4(11, 12, 13, 14); Fxi_13 = DW'(6); Fxi_23 = DW'(7);
        step();
        in_valid = 1'b0; nl_start = 1'b0; Fxi_13 = DW'(0); Fxi_23 = DW'(0);
        checks++; if (TB_dina !== pack4(11, 12, 13, 14) || TB_wea !== 4'b1111 || TB_dina_valid !== 1'b1)
            begin failures++; $display("FAIL same_cb got=%h/%b exp=%h/1111", TB_dina, TB_wea, pack4(11, 12, 13, 14)); end
        checks++; if (nl_busy !== 1'b1 || nl_done !== 1'b0) begin failures++; $display("FAIL same_busy got=%b%b exp=10", nl_busy, nl_done); end
        for (int r = 1; r <= 5; r++) begin
            step();
            checks++; if (TB_dina !== jrow(r, 6, 7) || nl_done !== (r == 5) || nl_busy !== 1'b1)
                begin failures++; $display("FAIL same_row%0d got=%h done=%b busy=%b exp=%h", r, TB_dina, nl_done, nl_busy, jrow(r, 6, 7)); end
        end
        step();
        checks++; if (TB_dina_valid !== 1'b0) begin failures++; $display("FAIL same_after got=%b exp=0", TB_dina_valid); end
    endtask

    task automatic test_reset_mid();
        TB_dina_sel = 3'b100; nl_start = 1'b1; Fxi_13 = DW'(3); Fxi_23 = DW'(8);
        for (int r = 1; r <= 3; r++) begin
            step();
            nl_start = 1'b0;
            checks++; if (TB_dina !== jrow(r, 3, 8)) begin failures++; $display("FAIL mid_row%0d got=%h exp=%h", r, TB_dina, jrow(r, 3, 8)); end
        end
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        checks++; if (TB_dina !== '0 || TB_wea !== '0 || {TB_dina_valid, nl_busy, nl_done, drop_err} !== 4'b0000)
            begin failures++; $display("FAIL mid_reset got=%h/%b/%b exp=0/0/0000", TB_dina, TB_wea, {TB_dina_valid, nl_busy, nl_done, drop_err}); end
        step();
        checks++; if (TB_dina_valid !== 1'b0 || nl_done !== 1'b0) begin failures++; $display("FAIL mid_quiet got=%b%b exp=00", TB_dina_valid, nl_done); end
        nl_start = 1'b1; Fxi_13 = DW'(1); Fxi_23 = DW'(2);
        for (int r = 1; r <= 5; r++) begin
            step();
            nl_start = 1'b0;
            checks++; if (TB_dina !== jrow(r, 1, 2) || nl_done !== (r == 5))
                begin failures++; $display("FAIL fresh_row%0d got=%h done=%b exp=%h", r, TB_dina, nl_done, jrow(r, 1, 2)); end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_pos();
        test_neg();
        test_new();
        test_nl_sequence();
        test_drop_and_restart();
        test_same_cycle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tb_dina_map_gen.md
Name: tb_dina_map_gen

Overview:
- Parametrised write-data mapper for the temp-buffer (TB) port A of the systolic-array datapath.
- Maps L-lane CB read data into TB_dina in positive, reversed or "new landmark" placement, with a registered valid and per-lane write mask.
- Replaces the externally sequenced nonlinear path with an internal FSM that emits the 5-row motion-Jacobian pattern after a single start pulse, using Fxi_13/Fxi_23 latched at start.

Parameters:
- L, 4, lane count of TB_dina; must be >= 4.
- RSA_DW, 32, element width in bits (signed).
- NEW_W, 2, number of elements written in NEW mode; 1 <= NEW_W <= L.
- OFS_DW, 3, width of new_ofs; 2^OFS_DW >= L.
- ONE, 1, fixed-point encoding of 1.0 written into Jacobian rows.
- TB_DINA_SEL_DW, 3, width of TB_dina_sel.

Ports:
- clk  in  1  clock.
- sys_rst  in  1  synchronous, active-high reset.
- TB_dina_sel  in  TB_DINA_SEL_DW  bit[2]: 0 = CB path, 1 = NL path; bits[1:0]: 00 IDLE, 01 POS, 10 NEG, 11 NEW.
- in_valid  in  1  CB request strobe; qualifies TB_dina_CB_douta and TB_dina_sel.
- TB_dina_CB_douta  in  L*RSA_DW  CB read data; lane i at bits [i*RSA_DW +: RSA_DW].
- new_ofs  in  OFS_DW  first destination lane for NEW mode.
- nl_start  in  1  one-cycle pulse; starts the Jacobian sequence.
- Fxi_13, Fxi_23  in  RSA_DW each  Jacobian terms, sampled on an accepted nl_start.
- TB_dina  out  L*RSA_DW  registered write data.
- TB_wea  out  L  registered per-lane write enable.
- TB_dina_valid  out  1  registered; high when TB_dina/TB_wea are meaningful.
- nl_busy  out  1  high while the NL sequence is running.
- nl_done  out  1  one-cycle pulse, coincident with the last NL row on the output.
- drop_err  out  1  sticky; set when a CB request is discarded because NL is busy.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; latched Fxi registers cleared. A reset asserted mid-sequence aborts it, and no nl_done is produced.
- CB path, accepted when in_valid=1, sel[2]=0 and FSM in IDLE. Latency is 1 cycle to TB_dina/TB_wea/TB_dina_valid.
  - POS: TB_dina = CB data; TB_wea = all ones.
  - NEG: lane i = CB lane L-1-i; TB_wea = all ones.
  - NEW: for k < NEW_W, lane new_ofs+k = CB lane k.
    - Destinations with new_ofs+k >= L are clipped: not written, wea bit 0.
    - All other lanes are 0 with wea bit 0.
  - IDLE: TB_dina = 0; TB_wea = 0; TB_dina_valid = 1.
- When in_valid=0 and no NL row is due: TB_dina = 0, TB_wea = 0, TB_dina_valid = 0.
- FSM states:
  - IDLE: nl_start=1 with sel[2]=1 latches Fxi_13/Fxi_23, sets cnt=1 and moves to RUN; nl_busy rises the next cycle. nl_start with sel[2]=0 is ignored.
  - RUN: emits one row per cycle, cnt = 1..5.
    - Each row has TB_dina_valid=1, TB_wea = all ones, and lanes >= 4 = 0.
    - Rows give lanes [0,1,2,3]: 1: [F13,0,0,0]; 2: [ONE,F23,0,0]; 3: [0,0,ONE,0]; 4: [0,ONE,F13,0]; 5: [0,0,F23,0].
    - At cnt=5, nl_done pulses with the row, then the FSM returns to IDLE.
- Timing: first row appears on the output one cycle after nl_start; the total sequence is 5 consecutive valid cycles.
- While in RUN:
  - nl_start is ignored.
  - Any in_valid=1 with sel[2]=0 is dropped and sets drop_err. drop_err clears only on reset.
  - Fxi input changes have no effect.
- Same cycle as an accepted nl_start with in_valid=1 CB request: the CB request is served on the next output cycle, the FSM enters RUN, and the first NL row follows one cycle later.
  - The whole NL sequence therefore shifts by 1 cycle; the rows are not lost.
  - nl_busy covers that cycle.
- All data is passed through unmodified: no arithmetic and no sign extension.

Test Plan:
- Reset then POS: CB lanes {10,20,30,40}, in_valid=1 -> next cycle TB_dina {10,20,30,40}, TB_wea=4'b1111, valid=1; the cycle after, valid=0 and TB_dina=0.
- NEG: CB {1,2,3,4} -> TB_dina {4,3,2,1}, wea=1111. NEW with new_ofs=2, CB {7,8,x,x} -> {0,0,7,8}, wea=1100. NEW with new_ofs=3 -> {0,0,0,7}, wea=1000 (clipped).
- nl_start with Fxi_13=5, Fxi_23=-3; change both inputs to 99 next cycle -> 5 rows {5,0,0,0},{1,-3,0,0},{0,0,1,0},{0,1,5,0},{0,0,-3,0}; nl_done on row 5 only; nl_busy 5 cycles.
- CB request during RUN -> no CB data appears, drop_err=1 and stays 1 after the sequence; a second nl_start during RUN does not restart the count.
- Same-cycle nl_start plus POS request -> POS data output first, NL rows on the following 5 cycles.
- sys_rst at cnt=3 -> next cycle all outputs 0, nl_busy=0, no nl_done; a fresh nl_start yields the full 5 rows.
